// File: rtl/alu_trace_display.sv
// Operand/control register file for an external ALU with a circular result
// history, exposed slot-by-slot to an LCD through registered display outputs.
module alu_trace_display #(
    parameter int CTRL_W     = 12,
    parameter int HIST_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        input_sel,
    input  logic              input_valid,
    input  logic [31:0]       input_value,
    input  logic [5:0]        display_number,
    input  logic [31:0]       alu_result,
    output logic [CTRL_W-1:0] alu_control,
    output logic [31:0]       alu_src1,
    output logic [31:0]       alu_src2,
    output logic              display_valid,
    output logic [39:0]       display_name,
    output logic [31:0]       display_value
);

    localparam int         PTR_W     = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int         CNT_W     = 5;
    localparam logic [5:0] LAST_SLOT = 6'(6 + HIST_DEPTH);

    localparam logic [39:0] NAME_SRC1  = 40'h5352435F31;
    localparam logic [39:0] NAME_SRC2  = 40'h5352435F32;
    localparam logic [39:0] NAME_CONTR = 40'h434F4E5452;
    localparam logic [39:0] NAME_RESUL = 40'h524553554C;
    localparam logic [39:0] NAME_COUNT = 40'h434F554E54;
    localparam logic [39:0] NAME_TOTAL = 40'h544F54414C;

    // "HIS" followed by the two decimal digits of the history age k
    function automatic logic [39:0] hist_name(input logic [5:0] k);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = k / 6'd10;
        ones = k % 6'd10;
        return {24'h484953, 8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}};
    endfunction

    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      total_r;
    logic [31:0]      hist_r [HIST_DEPTH];

    logic             cmd_s;
    logic             clear_s;
    logic             capture_s;
    logic [5:0]       k_s;
    logic [5:0]       idx_sum_s;
    logic [PTR_W-1:0] idx_s;
    logic             valid_s;
    logic [39:0]      name_s;
    logic [31:0]      value_s;

    // Clear outranks capture when both command bits are set
    assign cmd_s     = input_valid && (input_sel == 2'b01);
    assign clear_s   = cmd_s && input_value[1];
    assign capture_s = cmd_s && input_value[0] && !input_value[1];

    // Operand/control registers, history bookkeeping and capture total
    always_ff @(posedge clk) begin
        if (!resetn) begin
            alu_control <= '0;
            alu_src1    <= 32'd0;
            alu_src2    <= 32'd0;
            count_r     <= '0;
            wr_ptr_r    <= '0;
            total_r     <= 32'd0;
        end else begin
            if (input_valid && (input_sel == 2'b00)) begin
                alu_control <= input_value[CTRL_W-1:0];
            end
            if (input_valid && (input_sel == 2'b10)) begin
                alu_src1 <= input_value;
            end
            if (input_valid && (input_sel == 2'b11)) begin
                alu_src2 <= input_value;
            end
            if (clear_s) begin
                count_r  <= '0;
                wr_ptr_r <= '0;
            end else if (capture_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(HIST_DEPTH - 1)) ? '0 : wr_ptr_r + 1'b1;
                if (count_r != CNT_W'(HIST_DEPTH)) begin
                    count_r <= count_r + 1'b1;
                end
            end
            if (capture_s) begin
                total_r <= total_r + 32'd1;
            end
        end
    end

    // History storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        if (resetn && capture_s) begin
            hist_r[wr_ptr_r] <= alu_result;
        end
    end

    // Slot decode; entry k is k captures before the newest (wr_ptr - 1 - k)
    always_comb begin
        k_s       = display_number - 6'd7;
        idx_sum_s = {{(6-PTR_W){1'b0}}, wr_ptr_r} + 6'(2 * HIST_DEPTH - 1) - k_s;
        idx_s     = PTR_W'(idx_sum_s % 6'(HIST_DEPTH));
        valid_s   = 1'b0;
        name_s    = 40'd0;
        value_s   = 32'd0;
        case (display_number)
            6'd1: begin valid_s = 1'b1; name_s = NAME_SRC1;  value_s = alu_src1; end
            6'd2: begin valid_s = 1'b1; name_s = NAME_SRC2;  value_s = alu_src2; end
            6'd3: begin valid_s = 1'b1; name_s = NAME_CONTR; value_s = 32'(alu_control); end
            6'd4: begin valid_s = 1'b1; name_s = NAME_RESUL; value_s = alu_result; end
            6'd5: begin valid_s = 1'b1; name_s = NAME_COUNT; value_s = {27'd0, count_r}; end
            6'd6: begin valid_s = 1'b1; name_s = NAME_TOTAL; value_s = total_r; end
            default: begin
                if ((display_number >= 6'd7) && (display_number <= LAST_SLOT)
                    && (k_s < {1'b0, count_r})) begin
                    valid_s = 1'b1;
                    name_s  = hist_name(k_s);
                    value_s = hist_r[idx_s];
                end else begin
                    valid_s = 1'b0;
                    name_s  = 40'd0;
                    value_s = 32'd0;
                end
            end
        endcase
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            display_valid <= 1'b0;
            display_name  <= 40'd0;
            display_value <= 32'd0;
        end else begin
            display_valid <= valid_s;
            display_name  <= name_s;
            display_value <= value_s;
        end
    end

endmodule

// File: tb/tb_alu_trace_display.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of the register file, history and display slots.
module tb_alu_trace_display;

    localparam int CTRL_W     = 12;
    localparam int HIST_DEPTH = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [1:0]        input_sel;
    logic              input_valid;
    logic [31:0]       input_value;
    logic [5:0]        display_number;
    logic [31:0]       alu_result;
    logic [CTRL_W-1:0] alu_control;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic              display_valid;
    logic [39:0]       display_name;
    logic [31:0]       display_value;

    alu_trace_display #(.CTRL_W(CTRL_W), .HIST_DEPTH(HIST_DEPTH)) dut (
        .clk(clk), .resetn(resetn), .input_sel(input_sel), .input_valid(input_valid),
        .input_value(input_value), .display_number(display_number), .alu_result(alu_result),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .display_valid(display_valid), .display_name(display_name), .display_value(display_value)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: newest history entry at the front of the queue
    logic [31:0]       hist_q [$];
    logic [CTRL_W-1:0] ctrl_m;
    logic [31:0]       src1_m;
    logic [31:0]       src2_m;
    logic [31:0]       total_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rstn, input logic [1:0] sel, input logic vld,
                        input logic [31:0] val, input logic [5:0] dn, input logic [31:0] res);
        logic        ev;
        logic [39:0] en;
        logic [31:0] eval;
        int          k;
        logic [7:0]  d10;
        logic [7:0]  d1;
        @(negedge clk);
        resetn = rstn; input_sel = sel; input_valid = vld;
        input_value = val; display_number = dn; alu_result = res;
        ev = 1'b0; en = 40'd0; eval = 32'd0;
        if (rstn) begin
            case (dn)
                6'd1: begin ev = 1'b1; en = "SRC_1"; eval = src1_m; end
                6'd2: begin ev = 1'b1; en = "SRC_2"; eval = src2_m; end
                6'd3: begin ev = 1'b1; en = "CONTR"; eval = 32'(ctrl_m); end
                6'd4: begin ev = 1'b1; en = "RESUL"; eval = res; end
                6'd5: begin ev = 1'b1; en = "COUNT"; eval = hist_q.size(); end
                6'd6: begin ev = 1'b1; en = "TOTAL"; eval = total_m; end
                default: begin
                    k = int'(dn) - 7;
                    if (k >= 0 && k < HIST_DEPTH && k < hist_q.size()) begin
                        d10  = 8'(48 + k / 10);
                        d1   = 8'(48 + k % 10);
                        ev   = 1'b1;
                        en   = {"HIS", d10, d1};
                        eval = hist_q[k];
                    end
                end
            endcase
        end
        @(posedge clk);
        if (!rstn) begin
            ctrl_m = '0; src1_m = 32'd0; src2_m = 32'd0; total_m = 32'd0;
            hist_q.delete();
        end else if (vld) begin
            if (sel == 2'b00) ctrl_m = val[CTRL_W-1:0];
            if (sel == 2'b10) src1_m = val;
            if (sel == 2'b11) src2_m = val;
            if (sel == 2'b01 && val[1]) begin
                hist_q.delete();
            end else if (sel == 2'b01 && val[0]) begin
                hist_q.push_front(res);
                if (hist_q.size() > HIST_DEPTH) void'(hist_q.pop_back());
                total_m = total_m + 32'd1;
            end
        end
        #1;
        check("disp_valid", 64'(display_valid), 64'(ev));
        check("disp_name",  64'(display_name),  64'(en));
        check("disp_value", 64'(display_value), 64'(eval));
        check("alu_control", 64'(alu_control), 64'(ctrl_m));
        check("alu_src1", 64'(alu_src1), 64'(src1_m));
        check("alu_src2", 64'(alu_src2), 64'(src2_m));
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 32'd0, 6'd0, 32'd0);
    endtask

    initial begin
        logic [1:0]  s;
        logic [31:0] v;
        int          r;
        ctrl_m = '0; src1_m = 32'd0; src2_m = 32'd0; total_m = 32'd0;
        resetn = 1'b0; input_sel = 2'b00; input_valid = 1'b0;
        input_value = 32'd0; display_number = 6'd0; alu_result = 32'd0;

        // Reset state
        do_reset();
        check("rst_dvalid", 64'(display_valid), 64'd0);
        check("rst_src1", 64'(alu_src1), 64'd0);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd5, 32'd0);
        check("rst_count", 64'(display_value), 64'd0);

        // Basic operand load and capture
        step(1'b1, 2'b10, 1'b1, 32'd5, 6'd0, 32'd0);
        step(1'b1, 2'b11, 1'b1, 32'd3, 6'd1, 32'd0);
        check("src1_slot", 64'(display_value), 64'd5);
        step(1'b1, 2'b01, 1'b1, 32'd1, 6'd2, 32'd8);
        check("src2_slot", 64'(display_value), 64'd3);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd5, 32'd0);
        check("basic_count", 64'(display_value), 64'd1);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd7, 32'd0);
        check("basic_his00_name", 64'(display_name), 64'h4849533030);
        check("basic_his00_val", 64'(display_value), 64'd8);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd8, 32'd0);
        check("basic_his01_valid", 64'(display_valid), 64'd0);

        // Wrap-around: captures of 1..10 into an 8-deep history
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, 2'b01, 1'b1, 32'd1, 6'd0, 32'(i));
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd5, 32'd0);
        check("wrap_count", 64'(display_value), 64'd8);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd6, 32'd0);
        check("wrap_total", 64'(display_value), 64'd10);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd7, 32'd0);
        check("wrap_his00", 64'(display_value), 64'd10);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd14, 32'd0);
        check("wrap_his07", 64'(display_value), 64'd3);
        check("wrap_his07_name", 64'(display_name), 64'h4849533037);

        // Clear wins over capture; total preserved
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b1, 32'd1, 6'd0, 32'(100 + i));
        step(1'b1, 2'b01, 1'b1, 32'd3, 6'd0, 32'd77);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd5, 32'd0);
        check("clr_count", 64'(display_value), 64'd0);
        for (int i = 7; i <= 14; i++) begin
            step(1'b1, 2'b00, 1'b0, 32'd0, 6'(i), 32'd0);
            check("clr_his_invalid", 64'(display_valid), 64'd0);
        end
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd6, 32'd0);
        check("clr_total", 64'(display_value), 64'd4);

        // Control width truncation
        step(1'b1, 2'b00, 1'b1, 32'hFFFF_FABC, 6'd0, 32'd0);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd3, 32'd0);
        check("contr_name", 64'(display_name), 64'h434F4E5452);
        check("contr_val", 64'(display_value), 64'h0000_0ABC);

        // Reset beats a coincident capture
        step(1'b0, 2'b01, 1'b1, 32'd1, 6'd5, 32'd9);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd5, 32'd0);
        check("rstcap_count", 64'(display_value), 64'd0);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd6, 32'd0);
        check("rstcap_total", 64'(display_value), 64'd0);

        // Out-of-range slots
        step(1'b1, 2'b01, 1'b1, 32'd1, 6'd0, 32'd55);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd0, 32'd0);
        check("slot0_name", 64'(display_name), 64'd0);
        step(1'b1, 2'b00, 1'b0, 32'd0, 6'd44, 32'd0);
        check("slot44_valid", 64'(display_valid), 64'd0);
        check("slot44_value", 64'(display_value), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            s = 2'($urandom_range(0, 3));
            v = $urandom;
            if (s == 2'b01) begin
                r = $urandom_range(0, 9);
                v[1:0] = (r == 0) ? 2'b11 : (r == 1) ? 2'b10 : 2'b01;
            end
            step(($urandom_range(0, 80) != 0), s, ($urandom_range(0, 2) != 0), v,
                 ($urandom_range(0, 9) == 0) ? 6'd44 : 6'($urandom_range(0, 16)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
